multdiv_iterative: RTL

Iterative signed multiply/divide unit that answers the execute stage's multdiv request protocol. The processor issues a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse with operands valid, stalls, and waits for `data_resultRDY`. This block is the responder side of that exchange: it captures operands, runs a fixed-latency shift-add or restoring-divide sequence, and returns result, exception and a one-cycle ready pulse.

---
 rtl/multdiv_iterative_pkg.sv | 16 +
 rtl/multdiv_iterative_cond_negate.sv | 13 +
 rtl/multdiv_iterative.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multdiv_iterative_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states,
// default operand width, response latency and the MSB-only pattern.
package multdiv_iterative_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int LATENCY = DEFAULT_WIDTH + 1;
    localparam logic [DEFAULT_WIDTH-1:0] MSB_PATTERN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/multdiv_iterative_cond_negate.sv
// Combinational conditional two's-complement negate, used for operand
// magnitudes and for applying the result sign.
module multdiv_iterative_cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/multdiv_iterative.sv
// Iterative signed multiply (shift-add) / divide (restoring) responder with
// a fixed latency of WIDTH+1 edges from the start pulse to the ready pulse.
module multdiv_iterative
    import multdiv_iterative_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   signed_low;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   div_shifted;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   final_result;
    logic               final_exception;
    logic               sign;
    logic               op_div;
    logic [CW-1:0]      count;
    logic               start;
    logic               last_step;

    multdiv_iterative_cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .value  (data_operandA),
        .negate (data_operandA[WIDTH-1]),
        .result (abs_a)
    );

    multdiv_iterative_cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .value  (data_operandB),
        .negate (data_operandB[WIDTH-1]),
        .result (abs_b)
    );

    // Product low half and quotient both live in acc[WIDTH-1:0], so one negator serves both.
    multdiv_iterative_cond_negate #(.WIDTH(WIDTH)) u_sign_result (
        .value  (acc[WIDTH-1:0]),
        .negate (sign),
        .result (signed_low)
    );

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_step = (count == CW'(WIDTH - 1));

    always_comb begin
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : {WIDTH{1'b0}})};
        mul_next    = {mul_sum, acc[WIDTH-1:1]};
        div_shifted = {acc[2*WIDTH-2:WIDTH], mag_a[WIDTH-1]};
        div_diff    = {1'b0, div_shifted} - {1'b0, mag_b};
        div_rem     = div_diff[WIDTH] ? div_shifted : div_diff[WIDTH-1:0];
        div_next    = {div_rem, acc[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    // A negative product may reach exactly -2^(WIDTH-1); a positive one must stay below 2^(WIDTH-1).
    always_comb begin
        final_result    = signed_low;
        final_exception = 1'b0;
        if (op_div) begin
            if (mag_b == {WIDTH{1'b0}}) begin
                final_result    = {WIDTH{1'b0}};
                final_exception = 1'b1;
            end else if (!sign && acc[WIDTH-1]) begin
                final_result    = MSB_ONLY;
                final_exception = 1'b1;
            end
        end else if (acc[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}) begin
            final_exception = 1'b1;
        end else if (acc[WIDTH-1]) begin
            final_exception = !sign || (acc[WIDTH-2:0] != {(WIDTH-1){1'b0}});
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ctrl_MULT ? MUL : DIV;
        end else begin
            case (state)
                MUL, DIV: if (last_step) state_next = DONE;
                DONE:     state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Outputs latch at the end of the DONE cycle even if a new start arrives then.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            mag_a          <= '0;
            mag_b          <= '0;
            acc            <= '0;
            sign           <= 1'b0;
            op_div         <= 1'b0;
            count          <= '0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == DONE) begin
                data_result    <= final_result;
                data_exception <= final_exception;
                data_resultRDY <= 1'b1;
            end
            if (start) begin
                mag_a  <= abs_a;
                mag_b  <= abs_b;
                sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                op_div <= !ctrl_MULT;
                count  <= '0;
                acc    <= '0;
            end else if (state == MUL) begin
                acc   <= mul_next;
                mag_b <= mag_b >> 1;
                count <= count + CW'(1);
            end else if (state == DIV) begin
                acc   <= div_next;
                mag_a <= mag_a << 1;
                count <= count + CW'(1);
            end
        end
    end

endmodule
